// File: rtl/fp_addsub_seq_pkg.sv
// Shared types and constants for the multi-cycle binary32 add/subtract unit.
// Holds the FSM state encoding, special-value constants and the operand unpacker.
package fp_addsub_seq_pkg;

  typedef enum logic [2:0] {
    FPS_IDLE  = 3'd0,
    FPS_ALIGN = 3'd1,
    FPS_ADD   = 3'd2,
    FPS_NORM  = 3'd3,
    FPS_DONE  = 3'd4
  } fp_state_t;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [30:0] FP_INF_MAG = 31'h7F80_0000;
  localparam logic [7:0]  FP_EXP_MAX = 8'd255;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic [23:0] mant;
  } fp_unp_t;

  // Denormals flush to zero: a zero exponent yields a zero mantissa.
  function automatic fp_unp_t fp_unpack(input logic [31:0] v, input logic flip);
    fp_unp_t u;
    u.sign = v[31] ^ flip;
    u.exp  = v[30:23];
    u.frac = v[22:0];
    u.mant = (v[30:23] == 8'd0) ? 24'd0 : {1'b1, v[22:0]};
    return u;
  endfunction

endpackage

// File: rtl/fp_lzc24.sv
// Combinational leading-zero counter for a 24-bit mantissa sum.
// The count is 0 when the input is entirely zero; use the zero flag in that case.
module fp_lzc24 (
  input  logic [23:0] value,
  output logic [4:0]  count,
  output logic        zero
);

  logic found;

  always_comb begin
    count = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && value[i]) begin
        count = 5'(23 - i);
        found = 1'b1;
      end
    end
  end

  assign zero = ~|value;

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle binary32 add/subtract: IDLE -> ALIGN -> ADD -> NORM -> DONE.
// Truncating rounding, denormals flushed to zero, start/ready/done handshake.
module fp_addsub_seq
  import fp_addsub_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        invalid
);

  fp_state_t state, state_next;

  fp_unp_t     opa_q, opb_q;
  logic        nan_q;
  logic        sign_l_q, sign_s_q;
  logic [7:0]  exp_l_q;
  logic [23:0] mant_l_q, mant_s_q;
  logic [24:0] sum_q;
  logic [31:0] result_q;
  logic        overflow_q, invalid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FPS_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      FPS_IDLE: begin
        ready = 1'b1;
        if (start) state_next = FPS_ALIGN;
      end
      FPS_ALIGN: state_next = FPS_ADD;
      FPS_ADD:   state_next = FPS_NORM;
      FPS_NORM:  state_next = FPS_DONE;
      FPS_DONE: begin
        done       = 1'b1;
        state_next = FPS_IDLE;
      end
      default:   state_next = FPS_IDLE;
    endcase
  end

  // Alignment: the larger {exp, frac} becomes L, ties favour operand a.
  logic        a_ge_b;
  logic        sign_l_c, sign_s_c;
  logic [7:0]  exp_l_c, exp_s_c, exp_diff;
  logic [23:0] mant_l_c, mant_s_c, mant_s_al;

  always_comb begin
    a_ge_b    = {opa_q.exp, opa_q.frac} >= {opb_q.exp, opb_q.frac};
    sign_l_c  = a_ge_b ? opa_q.sign : opb_q.sign;
    sign_s_c  = a_ge_b ? opb_q.sign : opa_q.sign;
    exp_l_c   = a_ge_b ? opa_q.exp  : opb_q.exp;
    exp_s_c   = a_ge_b ? opb_q.exp  : opa_q.exp;
    mant_l_c  = a_ge_b ? opa_q.mant : opb_q.mant;
    mant_s_c  = a_ge_b ? opb_q.mant : opa_q.mant;
    exp_diff  = exp_l_c - exp_s_c;
    mant_s_al = (exp_diff >= 8'd24) ? 24'd0 : (mant_s_c >> exp_diff);
  end

  // L is never smaller than the aligned S, so the difference cannot go negative.
  logic [24:0] sum_c;

  always_comb begin
    if (sign_l_q ^ sign_s_q) sum_c = {1'b0, mant_l_q} - {1'b0, mant_s_q};
    else                     sum_c = {1'b0, mant_l_q} + {1'b0, mant_s_q};
  end

  logic [4:0]        lz;
  logic              lz_zero;
  logic [8:0]        exp_inc;
  logic signed [9:0] exp_dec;
  logic [22:0]       frac_shl;
  logic [31:0]       norm_result;
  logic              norm_ovf, norm_inv;

  fp_lzc24 u_lzc (
    .value (sum_q[23:0]),
    .count (lz),
    .zero  (lz_zero)
  );

  always_comb begin
    exp_inc     = {1'b0, exp_l_q} + 9'd1;
    exp_dec     = $signed({2'b00, exp_l_q}) - $signed({5'b00000, lz});
    frac_shl    = sum_q[22:0] << lz;
    norm_result = 32'd0;
    norm_ovf    = 1'b0;
    norm_inv    = 1'b0;
    if (nan_q) begin
      norm_result = FP_QNAN;
      norm_inv    = 1'b1;
    end else if (!sum_q[24] && lz_zero) begin
      norm_result = 32'd0;
    end else if (sum_q[24]) begin
      if (exp_inc == {1'b0, FP_EXP_MAX}) begin
        norm_result = {sign_l_q, FP_INF_MAG};
        norm_ovf    = 1'b1;
      end else begin
        norm_result = {sign_l_q, exp_inc[7:0], sum_q[23:1]};
      end
    end else if (exp_dec <= 10'sd0) begin
      norm_result = {sign_l_q, 31'd0};
    end else begin
      norm_result = {sign_l_q, exp_dec[7:0], frac_shl};
    end
  end

  // Each stage's registers load only in their own state; outputs hold between operations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q      <= '0;
      opb_q      <= '0;
      nan_q      <= 1'b0;
      sign_l_q   <= 1'b0;
      sign_s_q   <= 1'b0;
      exp_l_q    <= 8'd0;
      mant_l_q   <= 24'd0;
      mant_s_q   <= 24'd0;
      sum_q      <= 25'd0;
      result_q   <= 32'd0;
      overflow_q <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      case (state)
        FPS_IDLE: begin
          if (start) begin
            opa_q <= fp_unpack(a, 1'b0);
            opb_q <= fp_unpack(b, op);
            nan_q <= (a[30:23] == FP_EXP_MAX) || (b[30:23] == FP_EXP_MAX);
          end
        end
        FPS_ALIGN: begin
          sign_l_q <= sign_l_c;
          sign_s_q <= sign_s_c;
          exp_l_q  <= exp_l_c;
          mant_l_q <= mant_l_c;
          mant_s_q <= mant_s_al;
        end
        FPS_ADD: sum_q <= sum_c;
        FPS_NORM: begin
          result_q   <= norm_result;
          overflow_q <= norm_ovf;
          invalid_q  <= norm_inv;
        end
        default: ;
      endcase
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;
  assign invalid  = invalid_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq: handshake timing, arithmetic corner cases,
// back-to-back starts and mid-operation reset.
module tb_fp_addsub_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        invalid;

  int n_checks = 0;
  int n_fail   = 0;

  fp_addsub_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .overflow (overflow),
    .invalid  (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // One full operation with the handshake checked at every cycle of the latency.
  task automatic apply_stimulus(input string tag, input logic [31:0] av, input logic [31:0] bv,
                                input logic opv, input logic [31:0] er, input logic eo,
                                input logic ei);
    @(negedge clk);
    check_output({tag, ".ready_before"}, {31'd0, ready}, 32'd1);
    a = av; b = bv; op = opv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check_output({tag, ".ready_busy"}, {31'd0, ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_output({tag, ".done_early"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    check_output({tag, ".done"}, {31'd0, done}, 32'd1);
    check_output({tag, ".result"}, result, er);
    check_output({tag, ".overflow"}, {31'd0, overflow}, {31'd0, eo});
    check_output({tag, ".invalid"}, {31'd0, invalid}, {31'd0, ei});
    @(negedge clk);
    check_output({tag, ".done_fall"}, {31'd0, done}, 32'd0);
    check_output({tag, ".ready_back"}, {31'd0, ready}, 32'd1);
    check_output({tag, ".result_held"}, result, er);
  endtask

  logic [31:0] got [0:3];
  int          n_done;

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
    #2;
    check_output("reset.ready", {31'd0, ready}, 32'd1);
    check_output("reset.done", {31'd0, done}, 32'd0);
    check_output("reset.result", result, 32'd0);
    check_output("reset.overflow", {31'd0, overflow}, 32'd0);
    check_output("reset.invalid", {31'd0, invalid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    apply_stimulus("one_plus_one",   32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0);
    apply_stimulus("1p5_minus_1",    32'h3FC0_0000, 32'h3F80_0000, 1'b1, 32'h3F00_0000, 1'b0, 1'b0);
    apply_stimulus("1_minus_1p5",    32'h3F80_0000, 32'h3FC0_0000, 1'b1, 32'hBF00_0000, 1'b0, 1'b0);
    apply_stimulus("pi_minus_pi",    32'h4049_0FDB, 32'h4049_0FDB, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    apply_stimulus("shift_24_flush", 32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
    apply_stimulus("shift_23_keep",  32'h3F80_0000, 32'h3400_0000, 1'b0, 32'h3F80_0001, 1'b0, 1'b0);
    apply_stimulus("three_plus_neg1",32'h4040_0000, 32'hBF80_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0);
    apply_stimulus("denorm_flush",   32'h0040_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0);
    apply_stimulus("underflow_zero", 32'h0080_0000, 32'h00C0_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
    apply_stimulus("max_plus_max",   32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 1'b1, 1'b0);
    apply_stimulus("inf_operand",    32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 1'b0, 1'b1);

    // start held high for 12 edges; only edges 0, 5 and 10 may consume operands
    n_done = 0;
    for (int c = 0; c < 17; c++) begin
      if (c >= 12) begin
        start = 1'b0;
      end else begin
        start = 1'b1;
        case (c)
          0:       begin a = 32'h3F80_0000; b = 32'h3F80_0000; op = 1'b0; end
          5:       begin a = 32'h4000_0000; b = 32'h4000_0000; op = 1'b0; end
          10:      begin a = 32'h4040_0000; b = 32'h3F80_0000; op = 1'b1; end
          default: begin a = 32'h4120_0000; b = 32'h4120_0000; op = 1'b0; end
        endcase
      end
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        if (n_done < 4) got[n_done] = result;
        n_done++;
      end
    end
    check_output("held.done_count", n_done, 32'd3);
    check_output("held.result0", got[0], 32'h4000_0000);
    check_output("held.result1", got[1], 32'h4080_0000);
    check_output("held.result2", got[2], 32'h4000_0000);

    // reset while the operation sits in NORM
    @(negedge clk);
    a = 32'h3FC0_0000; b = 32'h3F80_0000; op = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("abort.ready", {31'd0, ready}, 32'd1);
    check_output("abort.done", {31'd0, done}, 32'd0);
    check_output("abort.result", result, 32'd0);
    check_output("abort.overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_output("abort.no_done", n_done, 32'd0);
    apply_stimulus("after_abort", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
